// File: rtl/arbitro_banco_reg_if.sv
// arbitro_banco_reg_if: bundles both masters' command/response signals and the register-file port.
interface arbitro_banco_reg_if #(
  parameter int LARGURA  = 32,
  parameter int LARG_END = 2
);
  logic                ReqA, EscA, GntA, ValidoA;
  logic [LARG_END-1:0] RegEscA, Fonte1A, Fonte2A;
  logic [LARGURA-1:0]  DadoA, Dado1A, Dado2A;
  logic                ReqB, EscB, GntB, ValidoB;
  logic [LARG_END-1:0] RegEscB, Fonte1B, Fonte2B;
  logic [LARGURA-1:0]  DadoB, Dado1B, Dado2B;
  logic                Esc;
  logic [LARG_END-1:0] RegEsc, Fonte1, Fonte2;
  logic [LARGURA-1:0]  Dado, Dado1, Dado2;
  modport slave (
    input  ReqA, EscA, RegEscA, Fonte1A, Fonte2A, DadoA,
    input  ReqB, EscB, RegEscB, Fonte1B, Fonte2B, DadoB,
    input  Dado1, Dado2,
    output GntA, ValidoA, Dado1A, Dado2A,
    output GntB, ValidoB, Dado1B, Dado2B,
    output Esc, RegEsc, Fonte1, Fonte2, Dado
  );
  modport master (
    output ReqA, EscA, RegEscA, Fonte1A, Fonte2A, DadoA,
    output ReqB, EscB, RegEscB, Fonte1B, Fonte2B, DadoB,
    output Dado1, Dado2,
    input  GntA, ValidoA, Dado1A, Dado2A,
    input  GntB, ValidoB, Dado1B, Dado2B,
    input  Esc, RegEsc, Fonte1, Fonte2, Dado
  );
endinterface

// File: rtl/arbitro_banco_reg.sv
// arbitro_banco_reg: round-robin arbiter giving masters A/B one register-file access per 3 cycles.
// Defining ARBITRO_CONT_GNT_EN adds saturating per-master grant counters ContA/ContB.
module arbitro_banco_reg #(
  parameter int LARGURA  = 32,
  parameter int LARG_END = 2
) (
  input  logic Clk,
  input  logic Rst,
`ifdef ARBITRO_CONT_GNT_EN
  output logic [15:0] ContA,
  output logic [15:0] ContB,
`endif
  arbitro_banco_reg_if.slave bus
);
  typedef enum logic [1:0] {OCIOSO, ACESSO, RESPOSTA} estado_t;
  estado_t estado_q, estado_d;
  logic ultimo_q, ultimo_d;
  logic esc_q, esc_d;
  logic [LARG_END-1:0] reg_esc_q, reg_esc_d, fonte1_q, fonte1_d, fonte2_q, fonte2_d;
  logic [LARGURA-1:0] dado_q, dado_d;
  logic [LARGURA-1:0] dado1a_q, dado1a_d, dado2a_q, dado2a_d, dado1b_q, dado1b_d, dado2b_q, dado2b_d;
  logic inicia, vence_b, acesso;
  // ultimo_q doubles as the current winner once a grant is issued (1 = B)
  always_comb begin
    vence_b  = bus.ReqB & (~bus.ReqA | ~ultimo_q);
    inicia   = (estado_q == OCIOSO) & (bus.ReqA | bus.ReqB);
    acesso   = estado_q == ACESSO;
    estado_d = inicia ? ACESSO : acesso ? RESPOSTA : OCIOSO;
    ultimo_d = inicia ? vence_b : ultimo_q;
    esc_d     = inicia ? (vence_b ? bus.EscB : bus.EscA) : esc_q;
    reg_esc_d = inicia ? (vence_b ? bus.RegEscB : bus.RegEscA) : reg_esc_q;
    fonte1_d  = inicia ? (vence_b ? bus.Fonte1B : bus.Fonte1A) : fonte1_q;
    fonte2_d  = inicia ? (vence_b ? bus.Fonte2B : bus.Fonte2A) : fonte2_q;
    dado_d    = inicia ? (vence_b ? bus.DadoB : bus.DadoA) : dado_q;
    dado1a_d = (acesso & ~ultimo_q) ? bus.Dado1 : dado1a_q;
    dado2a_d = (acesso & ~ultimo_q) ? bus.Dado2 : dado2a_q;
    dado1b_d = (acesso & ultimo_q) ? bus.Dado1 : dado1b_q;
    dado2b_d = (acesso & ultimo_q) ? bus.Dado2 : dado2b_q;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      estado_q  <= OCIOSO;
      ultimo_q  <= 1'b1;
      esc_q     <= 1'b0;
      reg_esc_q <= '0;
      fonte1_q  <= '0;
      fonte2_q  <= '0;
      dado_q    <= '0;
      dado1a_q  <= '0;
      dado2a_q  <= '0;
      dado1b_q  <= '0;
      dado2b_q  <= '0;
    end else begin
      estado_q  <= estado_d;
      ultimo_q  <= ultimo_d;
      esc_q     <= esc_d;
      reg_esc_q <= reg_esc_d;
      fonte1_q  <= fonte1_d;
      fonte2_q  <= fonte2_d;
      dado_q    <= dado_d;
      dado1a_q  <= dado1a_d;
      dado2a_q  <= dado2a_d;
      dado1b_q  <= dado1b_d;
      dado2b_q  <= dado2b_d;
    end
  end
  assign bus.GntA    = acesso & ~ultimo_q;
  assign bus.GntB    = acesso & ultimo_q;
  assign bus.ValidoA = (estado_q == RESPOSTA) & ~ultimo_q;
  assign bus.ValidoB = (estado_q == RESPOSTA) & ultimo_q;
  assign bus.Esc     = acesso & esc_q;
  assign bus.RegEsc  = reg_esc_q;
  assign bus.Fonte1  = fonte1_q;
  assign bus.Fonte2  = fonte2_q;
  assign bus.Dado    = dado_q;
  assign bus.Dado1A  = dado1a_q;
  assign bus.Dado2A  = dado2a_q;
  assign bus.Dado1B  = dado1b_q;
  assign bus.Dado2B  = dado2b_q;
`ifdef ARBITRO_CONT_GNT_EN
  logic [15:0] cont_a_q, cont_a_d, cont_b_q, cont_b_d;
  always_comb begin
    cont_a_d = (inicia & ~vence_b & (cont_a_q != 16'hFFFF)) ? cont_a_q + 16'd1 : cont_a_q;
    cont_b_d = (inicia & vence_b & (cont_b_q != 16'hFFFF)) ? cont_b_q + 16'd1 : cont_b_q;
  end
  always_ff @(posedge Clk) begin
    cont_a_q <= Rst ? 16'd0 : cont_a_d;
    cont_b_q <= Rst ? 16'd0 : cont_b_d;
  end
  assign ContA = cont_a_q;
  assign ContB = cont_b_q;
`endif
endmodule

// File: tb/tb_arbitro_banco_reg.sv
// tb_arbitro_banco_reg: directed and random two-master traffic checked against a transaction-level
// model; grants are predicted per cycle and responses are scoreboarded by a separate monitor.
module tb_arbitro_banco_reg;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  arbitro_banco_reg_if #(.LARGURA(32), .LARG_END(2)) bus ();
`ifdef ARBITRO_CONT_GNT_EN
  logic [15:0] ContA, ContB;
`endif
  arbitro_banco_reg #(.LARGURA(32), .LARG_END(2)) dut (
    .Clk(Clk),
    .Rst(Rst),
`ifdef ARBITRO_CONT_GNT_EN
    .ContA(ContA),
    .ContB(ContB),
`endif
    .bus(bus)
  );

  // register file the arbiter drives: sync write, combinational reads
  logic [31:0] rf [4] = '{default: '0};
  always @(posedge Clk) if (bus.Esc) rf[bus.RegEsc] <= bus.Dado;
  assign bus.Dado1 = rf[bus.Fonte1];
  assign bus.Dado2 = rf[bus.Fonte2];

  typedef struct packed {logic esc; logic [1:0] re; logic [1:0] f1; logic [1:0] f2; logic [31:0] d;} cmd_t;
  typedef struct {int m; int cyc; logic [31:0] d1; logic [31:0] d2;} exp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q[$];
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  function automatic cmd_t mk(input logic esc, input logic [1:0] re, input logic [1:0] f1,
                              input logic [1:0] f2, input logic [31:0] d);
    cmd_t c;
    c.esc = esc; c.re = re; c.f1 = f1; c.f2 = f2; c.d = d;
    return c;
  endfunction

  function automatic cmd_t rnd();
    return mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), $urandom);
  endfunction

  // reference model: a grant follows any request seen while idle; idle resumes 2 cycles after a grant
  cmd_t pa, pb;
  logic p_ra = 1'b0, p_rb = 1'b0, p_rst = 1'b1, ult_b = 1'b1;
  int last_g = -100;
  logic [31:0] mrf [4] = '{default: '0};
  always @(negedge Clk) begin
    logic ea, eb;
    cmd_t c;
    exp_t e;
    if (p_rst) begin ult_b = 1'b1; last_g = -100; end
    ea = 1'b0;
    eb = 1'b0;
    if (!p_rst && cyc - 1 >= last_g + 2 && (p_ra || p_rb)) begin
      if (p_ra && p_rb) eb = !ult_b;
      else eb = p_rb;
      ea = !eb;
    end
    chk("GntA", bus.GntA, ea);
    chk("GntB", bus.GntB, eb);
    c = eb ? pb : pa;
    chk("Esc", bus.Esc, (ea || eb) && c.esc);
    if (ea || eb) begin
      chk("RegEsc", bus.RegEsc, c.re);
      chk("Fonte1", bus.Fonte1, c.f1);
      chk("Fonte2", bus.Fonte2, c.f2);
      chk("Dado", bus.Dado, c.d);
      e.m = eb ? 1 : 0;
      e.cyc = cyc + 1;
      e.d1 = mrf[c.f1];
      e.d2 = mrf[c.f2];
      q.push_back(e);
      if (c.esc) mrf[c.re] = c.d;
      ult_b = eb;
      last_g = cyc;
    end
    pa = mk(bus.EscA, bus.RegEscA, bus.Fonte1A, bus.Fonte2A, bus.DadoA);
    pb = mk(bus.EscB, bus.RegEscB, bus.Fonte1B, bus.Fonte2B, bus.DadoB);
    p_ra = bus.ReqA;
    p_rb = bus.ReqB;
    p_rst = Rst;
  end

  // response monitor: pops the scoreboard on Valido and checks the held read data every cycle
  logic [31:0] h [4];
  logic m_rst = 1'b1;
  always @(negedge Clk) begin
    logic va, vb;
    if (m_rst) begin q.delete(); h = '{default: '0}; end
    while (q.size() > 0 && q[0].cyc < cyc) void'(q.pop_front());
    va = q.size() > 0 && q[0].cyc == cyc && q[0].m == 0;
    vb = q.size() > 0 && q[0].cyc == cyc && q[0].m == 1;
    chk("ValidoA", bus.ValidoA, va);
    chk("ValidoB", bus.ValidoB, vb);
    if (va || vb) begin
      h[q[0].m * 2] = q[0].d1;
      h[q[0].m * 2 + 1] = q[0].d2;
      void'(q.pop_front());
    end
    chk("Dado1A", bus.Dado1A, h[0]);
    chk("Dado2A", bus.Dado2A, h[1]);
    chk("Dado1B", bus.Dado1B, h[2]);
    chk("Dado2B", bus.Dado2B, h[3]);
    m_rst = Rst;
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic drive(input int m, input logic r, input cmd_t c);
    if (m == 0) begin
      bus.ReqA = r; bus.EscA = c.esc; bus.RegEscA = c.re; bus.Fonte1A = c.f1; bus.Fonte2A = c.f2; bus.DadoA = c.d;
    end else begin
      bus.ReqB = r; bus.EscB = c.esc; bus.RegEscB = c.re; bus.Fonte1B = c.f1; bus.Fonte2B = c.f2; bus.DadoB = c.d;
    end
  endtask

  task automatic go(input int m, input cmd_t c);
    int k;
    drive(m, 1'b1, c);
    for (k = 0; k < 10; k++) begin
      tick();
      if (m == 1 ? bus.GntB : bus.GntA) break;
    end
    chk("gnt_wait", k < 10, 1);
    drive(m, 1'b0, c);
  endtask

  initial begin
    logic [3:0] ordem;
    int tg [4];
    int ng, k;
    ordem = '0;
    tg = '{default: 0};
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    tick();
    tick();
    chk("reset_ctl", {bus.GntA, bus.GntB, bus.ValidoA, bus.ValidoB, bus.Esc, bus.RegEsc, bus.Fonte1, bus.Fonte2}, 0);
    chk("reset_dado", {bus.Dado, bus.Dado1A}, 0);
    chk("reset_resp", {bus.Dado2A, bus.Dado1B}, 0);
    chk("reset_dado2b", bus.Dado2B, 0);
    Rst = 1'b0;
    tick();
    go(0, mk(1'b1, 2'd2, 2'd0, 2'd0, 32'h048fc24a));
    go(1, mk(1'b0, 2'd0, 2'd2, 2'd0, 32'h0));
    tick();
    tick();
    chk("leB_dado1", bus.Dado1B, 32'h048fc24a);
    chk("leB_dado2", bus.Dado2B, 32'h0);
    drive(0, 1'b1, mk(1'b0, 2'd0, 2'd1, 2'd2, 32'h0));
    drive(1, 1'b1, mk(1'b0, 2'd0, 2'd3, 2'd2, 32'h0));
    ng = 0;
    for (int i = 0; i < 30 && ng < 4; i++) begin
      tick();
      if (bus.GntA || bus.GntB) begin
        ordem[ng] = bus.GntB;
        tg[ng] = cyc;
        ng++;
      end
    end
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    chk("rr_count", ng, 4);
    chk("rr_order", ordem, 4'b1010);
    for (int i = 1; i < 4; i++) chk("rr_gap", tg[i] - tg[i-1], 3);
    go(0, mk(1'b1, 2'd1, 2'd0, 2'd0, 32'h4));
    go(0, mk(1'b1, 2'd1, 2'd1, 2'd1, 32'h9));
    tick();
    tick();
    chk("rbw_old", bus.Dado1A, 32'h4);
    go(0, mk(1'b0, 2'd0, 2'd1, 2'd0, 32'h0));
    tick();
    tick();
    chk("rbw_new", bus.Dado1A, 32'h9);
    drive(0, 1'b1, mk(1'b1, 2'd3, 2'd0, 2'd0, 32'h6));
    for (k = 0; k < 10; k++) begin
      tick();
      if (bus.GntA) break;
    end
    chk("rst_gnt_wait", k < 10, 1);
    drive(0, 1'b0, '0);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk("rst_no_valido", bus.ValidoA, 0);
    chk("rst_idle", {bus.GntA, bus.GntB, bus.Esc}, 0);
    go(1, mk(1'b0, 2'd0, 2'd3, 2'd3, 32'h0));
    tick();
    tick();
    chk("rst_write_kept", bus.Dado1B, 32'h6);
    for (int i = 0; i < 400; i++) begin
      tick();
      Rst = ($urandom_range(0, 79) == 0);
      for (int m = 0; m < 2; m++) begin
        if (m == 1 ? bus.GntB : bus.GntA) drive(m, 1'($urandom_range(0, 1)), rnd());
        else if (!(m == 1 ? bus.ReqB : bus.ReqA) && $urandom_range(0, 2) == 0) drive(m, 1'b1, rnd());
      end
    end
    Rst = 1'b0;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    repeat (6) tick();
    chk("queue_drained", q.size(), 0);
`ifdef ARBITRO_CONT_GNT_EN
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk("cont_reset", {ContA, ContB}, 0);
    repeat (5) go(0, rnd());
    repeat (3) go(1, rnd());
    tick();
    chk("ContA", ContA, 5);
    chk("ContB", ContB, 3);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk("cont_cleared", {ContA, ContB}, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/arbitro_banco_reg.md
Name: arbitro_banco_reg

Overview:
- Two-master arbiter and sequencer for the 4x32-bit register file (2-bit addresses, write on Clk edge when Esc=1, combinational reads).
- Masters A and B each issue one read/write command with a Req handshake.
- The arbiter grants one master round-robin, drives the register file for exactly one access cycle, and returns the registered read data with a Valido pulse.

Parameters:
- LARGURA, 32, data width of the register file.
- LARG_END, 2, register address width.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- ReqA  input  1  master A request; held until GntA is seen.
- EscA  input  1  master A command: 1 = write, 0 = read.
- RegEscA  input  LARG_END  master A write address.
- Fonte1A  input  LARG_END  master A read address, source 1.
- Fonte2A  input  LARG_END  master A read address, source 2.
- DadoA  input  LARGURA  master A write data.
- GntA  output  1  A command accepted; 1-cycle pulse.
- ValidoA  output  1  A response valid; 1-cycle pulse.
- Dado1A  output  LARGURA  read data, source 1, returned to A.
- Dado2A  output  LARGURA  read data, source 2, returned to A.
- ReqB, EscB, RegEscB, Fonte1B, Fonte2B, DadoB, GntB, ValidoB, Dado1B, Dado2B: same as A, for master B.
- RegEsc  output  LARG_END  register file write address.
- Fonte1  output  LARG_END  register file read address 1.
- Fonte2  output  LARG_END  register file read address 2.
- Dado  output  LARGURA  register file write data.
- Esc  output  1  register file write enable.
- Dado1  input  LARGURA  register file read data 1.
- Dado2  input  LARGURA  register file read data 2.

Behaviour:
- FSM states: OCIOSO, ACESSO, RESPOSTA.
- Transition OCIOSO -> ACESSO: at an edge with any Req=1.
  - Latch the winner's command (Esc, RegEsc, Fonte1, Fonte2, Dado) into internal registers.
  - Set the winner's Gnt to 1 and record the winner in Ultimo.
- OCIOSO with no Req: remain in OCIOSO.
- ACESSO -> RESPOSTA: always.
  - Gnt=1 for the granted master only.
  - The register file is driven from the latched command; Esc output = latched Esc (combinational from state), 0 in every other state.
  - At the edge: capture Dado1/Dado2 into the winner's Dado1X/Dado2X and set its Valido to 1.
- RESPOSTA -> OCIOSO: always. Valido=1 for one cycle.
- Latency and throughput:
  - Request seen in cycle t gives Gnt in t+1, the register file access in t+1, the write committed at the edge ending t+1, and Valido in t+2.
  - One transaction per 3 cycles.
- Writes:
  - Valido serves as the acknowledgement.
  - Dado1X/Dado2X return the pre-write values of Fonte1/Fonte2 sampled in the ACESSO cycle.
- Round-robin arbitration:
  - Both requesting: grant the master that is not Ultimo.
  - One requesting: grant it.
  - Ultimo resets to B, so A wins the first contention.
- Req is sampled only in OCIOSO.
  - A master that keeps Req high after Gnt is treated as issuing a new command.
  - Req changes during ACESSO/RESPOSTA are ignored.
- Dado1X/Dado2X hold their value until the next response to the same master.
- Register file address/data outputs hold the last latched command; they are don't-care when Esc=0.
- Reset values: state=OCIOSO; Ultimo=B; every Gnt, Valido and Esc=0; all latched command fields, RegEsc, Fonte1, Fonte2, Dado, Dado1A/B and Dado2A/B = 0.
- Rst asserted during ACESSO:
  - The in-flight write still commits at that edge, because Esc is 1 during the cycle.
  - Valido is suppressed and the state goes to OCIOSO.
- Rst during RESPOSTA: Valido drops at the next edge.

Optional Feature:
- Macro: ARBITRO_CONT_GNT_EN.
- When defined, add output ports ContA and ContB, 16 bits each.
  - Each counts grants issued to its master, incremented on the Gnt edge.
  - Saturating at 16'hFFFF; cleared by Rst.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then ReqA=1, EscA=1, RegEscA=2, DadoA=32'h048fc24a -> GntA=1 in t+1 with Esc=1, RegEsc=2; ValidoA=1 in t+2.
- Then ReqB=1, read with Fonte1B=2, Fonte2B=0 -> ValidoB=1 with Dado1B=32'h048fc24a and Dado2B=0.
- ReqA and ReqB both held high for 4 transactions -> grants in order A, B, A, B, each 3 cycles apart; Gnt never asserted for both masters together.
- A write to register 1 with Fonte1A=1 in the same command, register 1 previously 32'h00000004 -> Dado1A=32'h00000004 (old value); a following read returns the new value.
- Rst during ACESSO of a write of 32'h00000006 to register 3 -> no Valido; state OCIOSO; a later read of register 3 returns 32'h00000006.
- With ARBITRO_CONT_GNT_EN: 5 A grants and 3 B grants -> ContA=5, ContB=3; after Rst both are 0.
